// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } fetch_state_t;

  localparam logic [31:0] NOP     = 32'h0;
  localparam int          ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Circular queue with a registered head entry; flush empties it and wins over push/pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head_data,
  output logic                   head_valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]    count_next;
  logic [WIDTH-1:0] head_reg, head_next;
  logic             full, empty, push_eff, pop_eff, head_load;

  assign count      = wr_ptr_reg - rd_ptr_reg;
  assign empty      = (wr_ptr_reg == rd_ptr_reg);
  assign full       = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign head_valid = !empty;
  assign head_data  = head_reg;

  always_comb begin
    pop_eff     = pop && !empty && !flush;
    push_eff    = push && !flush && (!full || pop_eff);
    wr_ptr_next = wr_ptr_reg + PW'(push_eff);
    rd_ptr_next = rd_ptr_reg + PW'(pop_eff);
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end
    count_next = wr_ptr_next - rd_ptr_next;
    head_load  = (count_next != '0);
    // The slot becoming head is being written this cycle only when the queue goes to one entry.
    if (push_eff && (wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0])) begin
      head_next = push_data;
    end else begin
      head_next = mem[rd_ptr_next[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (push_eff) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      head_reg   <= WIDTH'({2{NOP}});
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      if (head_load) begin
        head_reg <= head_next;
      end
    end
  end

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetches one instruction per cycle into a small queue toward decode.
// Optional stall-cycle counter is enabled by defining IFQ_PERF_CNT_EN.
module instruction_fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int IMEM_AW = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        ins_address,
  input  logic               flush,
  output logic               imem_rd_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               fetch_stall,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [31:0]        id_instr,
  output logic [31:0]        id_pc
`ifdef IFQ_PERF_CNT_EN
  ,
  output logic [15:0]        stall_cycles
`endif
);

  localparam int PW = $clog2(DEPTH) + 1;

  fetch_state_t state_reg, state_next;
  logic         in_flight_reg;
  logic [31:0]  in_flight_pc_reg;
  logic [PW-1:0] count;
  logic [PW:0]   pending;
  logic          running;
  fetch_entry_t  push_entry, head_entry;

  assign imem_addr = ins_address[IMEM_AW+1:2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = S_RUN;
  end

  // Queued entries plus the read in flight must never exceed the queue depth.
  assign pending = {1'b0, count} + {{PW{1'b0}}, in_flight_reg};

  always_comb begin
    running     = (state_reg == S_RUN);
    fetch_stall = !running || (pending >= (PW+1)'(DEPTH));
    imem_rd_en  = running && !flush && !fetch_stall;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_flight_reg    <= 1'b0;
      in_flight_pc_reg <= '0;
    end else begin
      in_flight_reg <= imem_rd_en;
      if (imem_rd_en) begin
        in_flight_pc_reg <= ins_address;
      end
    end
  end

  assign push_entry.pc    = in_flight_pc_reg;
  assign push_entry.instr = imem_rdata;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (in_flight_reg),
    .push_data  (push_entry),
    .pop        (id_valid && id_ready),
    .flush      (flush),
    .head_data  (head_entry),
    .head_valid (id_valid),
    .count      (count)
  );

  assign id_pc    = head_entry.pc;
  assign id_instr = head_entry.instr;

`ifdef IFQ_PERF_CNT_EN
  logic [15:0] stall_cycles_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_reg <= '0;
    end else if (running && fetch_stall && (stall_cycles_reg != 16'hFFFF)) begin
      stall_cycles_reg <= stall_cycles_reg + 16'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
`endif

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Randomized scoreboard bench: a program-counter and memory model drive the queue; every fetched pc must reach decode in order unless flushed.
module tb_instruction_fetch_queue;
  localparam int DEPTH   = 4;
  localparam int IMEM_AW = 8;

  typedef struct {
    logic [31:0] pc;
    int          cyc;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               flush = 1'b0;
  logic               id_ready = 1'b0;
  logic [31:0]        target = '0;
  logic [31:0]        pc;
  logic [31:0]        ins_address;
  logic [31:0]        imem_rdata;
  logic               imem_rd_en, fetch_stall, id_valid;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        id_instr, id_pc;
`ifdef IFQ_PERF_CNT_EN
  logic [15:0]        stall_cycles;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   idle_cnt = 0;
  int   stall_model = 0;
  bit   run_exp = 1'b0;
  bit   stall_exp = 1'b1;
  exp_t q[$];

  instruction_fetch_queue #(
    .DEPTH   (DEPTH),
    .IMEM_AW (IMEM_AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ins_address (ins_address),
    .flush       (flush),
    .imem_rd_en  (imem_rd_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .fetch_stall (fetch_stall),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_pc       (id_pc)
`ifdef IFQ_PERF_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Program counter: branches on flush, holds while stalled.
  assign ins_address = pc;
  always @(posedge clk or negedge reset) begin
    if (!reset)            pc <= '0;
    else if (flush)        pc <= target;
    else if (!fetch_stall) pc <= pc + 32'd4;
  end

  // Instruction memory: one-cycle read latency, garbage when not read.
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= 32'hA000_0000 + {22'h0, imem_addr, 2'b00};
    else            imem_rdata <= $urandom;
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    logic [31:0] mask;
    mask = ((32'd1 << (IMEM_AW + 2)) - 32'd1) & 32'hFFFF_FFFC;
    return 32'hA000_0000 + (a & mask);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares outputs against the model, then retires accepted heads.
  initial begin
    bit exp_valid;
    exp_t h;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        q.delete();
        idle_cnt = 0;
        stall_model = 0;
        run_exp = 1'b0;
        stall_exp = 1'b1;
        chk("rst_id_valid", {31'h0, id_valid}, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_instr", id_instr, 32'h0);
        chk("rst_rd_en", {31'h0, imem_rd_en}, 32'h0);
        chk("rst_stall", {31'h0, fetch_stall}, 32'h1);
`ifdef IFQ_PERF_CNT_EN
        chk("rst_stall_cycles", {16'h0, stall_cycles}, 32'h0);
`endif
      end else begin
        run_exp   = (idle_cnt >= 1);
        stall_exp = !run_exp || (q.size() >= DEPTH);
        exp_valid = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
        chk("fetch_stall", {31'h0, fetch_stall}, {31'h0, stall_exp});
        chk("imem_rd_en", {31'h0, imem_rd_en}, {31'h0, run_exp && !flush && !stall_exp});
        chk("imem_addr", {24'h0, imem_addr}, {24'h0, pc[IMEM_AW+1:2]});
        chk("id_valid", {31'h0, id_valid}, {31'h0, exp_valid});
`ifdef IFQ_PERF_CNT_EN
        chk("stall_cycles", {16'h0, stall_cycles}, stall_model);
`endif
        if (exp_valid) begin
          h = q[0];
          if (id_valid) begin
            chk("id_pc", id_pc, h.pc);
            chk("id_instr", id_instr, instr_of(h.pc));
          end
          if (id_ready && !flush) void'(q.pop_front());
        end
        if (run_exp && stall_exp && stall_model < 65535) stall_model++;
        idle_cnt++;
      end
    end
  end

  // Scoreboard feed: every pc the program counter hands over is an expected delivery.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (reset) begin
        if (flush) begin
          q.delete();
        end else if (run_exp && !stall_exp) begin
          e.pc  = pc;
          e.cyc = cyc;
          q.push_back(e);
        end
      end
    end
  end

  task automatic step(input bit rdy, input bit fl, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    id_ready = rdy;
    flush    = fl;
    target   = tgt;
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] t;
      if ($urandom_range(7) == 0) t = $urandom & 32'hFFFF_FFFC;
      else                        t = $urandom_range(255) << 2;
      step($urandom_range(9) < 7, $urandom_range(19) == 0, t);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Streaming with decode always ready.
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 32'h0);
    // Decode blocked: queue fills to DEPTH and fetch stalls.
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 32'h0);
    // Drain while a flush redirects fetch.
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0200);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0);
    random_phase(1500);

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("async_id_valid", {31'h0, id_valid}, 32'h0);
    chk("async_id_pc", id_pc, 32'h0);
    chk("async_id_instr", id_instr, 32'h0);
    chk("async_rd_en", {31'h0, imem_rd_en}, 32'h0);
    chk("async_stall", {31'h0, fetch_stall}, 32'h1);
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    random_phase(400);

`ifdef IFQ_PERF_CNT_EN
    for (int i = 0; i < 65600; i++) step(1'b0, 1'b0, 32'h0);
`endif
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
